// File: rtl/count_ones_job_queue.sv
// count_ones_job_queue: buffers operand words in a small FIFO and runs them one
// at a time through the count-ones core. The core's sticky-done / restart
// handshake is handled here; results come out on a valid/ready stream in
// arrival order.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a queued word; pops it into job_reg when level != 0
// LAUNCH  | core_go high for this single cycle
// SETTLE  | core_go low; core_done ignored (may still be stale from last job)
// WAIT    | waiting for core_done
// CAPTURE | core_out moves into the result register once it is free
module count_ones_job_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_data,
  output logic                         busy,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         core_go,
  output logic [WIDTH-1:0]             core_in,
  input  logic                         core_done,
  input  logic [$clog2(WIDTH+1)-1:0]   core_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SETTLE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] job_reg;
  logic             push;
  logic             pop;

  assign in_ready = (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Popping only from IDLE gives the no-fall-through behaviour: a word pushed
  // at an edge is seen by IDLE in the following cycle at the earliest.
  assign pop      = (state == S_IDLE) && (level != '0);
  assign core_in  = job_reg;
  assign busy     = (state != S_IDLE);

  // FIFO storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Job sequencer with registered core_go and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      job_reg   <= '0;
      core_go   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          core_go <= 1'b0;
          if (pop) begin
            job_reg <= mem[rd_ptr];
            core_go <= 1'b1;
            state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          core_go <= 1'b0;
          state   <= S_SETTLE;
        end
        S_SETTLE: begin
          // A done seen here can belong to the previous job, so skip it.
          core_go <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          core_go <= 1'b0;
          if (core_done) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // core_out reloads on the done edge, so it is valid one cycle after
          // done was first seen and stays put while done remains sticky.
          core_go <= 1'b0;
          if (!out_valid || out_ready) begin
            out_data  <= CW'(core_out);
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          core_go <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_ones_job_queue.sv
// Directed bench for count_ones_job_queue with a behavioural count-ones core.
module tb_count_ones_job_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 5;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    out_data;
  logic             busy;
  logic [LW-1:0]    level;
  logic             core_go;
  logic [WIDTH-1:0] core_in;
  logic             core_done;
  logic [CW-1:0]    core_out;

  int total = 0;
  int bad   = 0;
  int go_cnt = 0;
  int go_base;
  logic [31:0] exq[$];

  count_ones_job_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .level(level),
    .core_go(core_go), .core_in(core_in),
    .core_done(core_done), .core_out(core_out)
  );

  always #5 clk = ~clk;

  // Behavioural count-ones core: START / COMPUTE / RESTART, sticky done.
  localparam logic [1:0] C_START = 2'd0, C_COMP = 2'd1, C_RESTART = 2'd2;
  logic [1:0]       c_st;
  logic [WIDTH-1:0] c_n;
  logic [CW-1:0]    c_cnt;
  logic [CW-1:0]    c_out;

  assign core_done = (c_st == C_COMP) && (c_n == '0);
  assign core_out  = c_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_st  <= C_START;
      c_n   <= '0;
      c_cnt <= '0;
      c_out <= '0;
    end else begin
      if (core_done) c_out <= c_cnt;
      case (c_st)
        C_START: if (core_go) begin
          c_n <= core_in; c_cnt <= '0; c_st <= C_COMP;
        end
        C_COMP: begin
          if (c_n == '0) begin
            if (core_go) c_st <= C_RESTART;
          end else begin
            c_cnt <= c_cnt + CW'(c_n[0]);
            c_n   <= c_n >> 1;
          end
        end
        default: begin
          c_n <= core_in; c_cnt <= '0; c_st <= C_COMP;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output scoreboard and core_in stability / go pulse monitors.
  logic             prev_go = 1'b0;
  logic [WIDTH-1:0] go_in = '0;
  always @(posedge clk) begin
    if (rst) begin
      prev_go = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exq.size() == 0) check("extra_result", 32'(out_data), 32'hFFFF_FFFF);
        else check("result_order", 32'(out_data), exq.pop_front());
      end
      if (prev_go) check("core_in_stable", 32'(core_in), 32'(go_in));
      prev_go = core_go;
      go_in   = core_in;
      if (core_go) go_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input logic [31:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin tick(); n++; end
    check("push_accepted", 32'(in_ready), 32'd1);
    exq.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exq.size() != 0 && n < budget) begin tick(); n++; end
    check("drain", 32'(exq.size()), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin tick(); n++; end
    check("wait_valid", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_level", 32'(level), 0);
    check("rst_core_go", 32'(core_go), 0);
    check("rst_core_in", 32'(core_in), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Zero operand from reset: minimum latency
    out_ready = 1'b0;
    push_word(16'h0000, 0);          // returns 1 after edge 0
    check("lat_c1_busy", 32'(busy), 0);
    check("lat_c1_level", 32'(level), 1);
    tick();                          // after edge 1: LAUNCH
    check("lat_c2_go", 32'(core_go), 1);
    check("lat_c2_core_in", 32'(core_in), 0);
    tick();                          // SETTLE
    check("lat_c3_go", 32'(core_go), 0);
    check("lat_c3_done", 32'(core_done), 1);
    tick();                          // WAIT
    check("lat_c4_valid", 32'(out_valid), 0);
    tick();                          // CAPTURE
    check("lat_c5_valid", 32'(out_valid), 0);
    tick();
    check("lat_c6_valid", 32'(out_valid), 1);
    check("lat_c6_data", 32'(out_data), 0);
    out_ready = 1'b1;
    tick();
    check("lat_clear", 32'(out_valid), 0);
    out_ready = 1'b0;

    // Single job with held result
    go_base = go_cnt;
    push_word(16'h00F0, 4);
    wait_valid(100);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_data", 32'(out_data), 4);
    end
    check("single_go_pulses", 32'(go_cnt - go_base), 1);
    out_ready = 1'b1;
    tick();
    check("single_clear", 32'(out_valid), 0);

    // Ordering and restart path
    go_base = go_cnt;
    push_word(16'hFFFF, 16);
    push_word(16'h0001, 1);
    push_word(16'h8000, 1);
    push_word(16'hAAAA, 8);
    drain(400);
    repeat (5) tick();
    check("order_go_pulses", 32'(go_cnt - go_base), 4);
    check("order_idle_busy", 32'(busy), 0);

    // FIFO full and backpressure stall
    out_ready = 1'b0;
    push_word(16'h0003, 2);
    push_word(16'h0F00, 4);
    push_word(16'h1111, 4);
    push_word(16'h7FFF, 15);
    push_word(16'h0101, 2);
    push_word(16'hC000, 2);
    repeat (80) tick();
    check("full_level", 32'(level), 4);
    check("full_in_ready", 32'(in_ready), 0);
    go_base = go_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_go", 32'(core_go), 0);
      check("stall_data", 32'(out_data), 2);
      check("stall_busy", 32'(busy), 1);
    end
    check("stall_go_pulses", 32'(go_cnt - go_base), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_next_valid", 32'(out_valid), 1);
    check("stall_next_data", 32'(out_data), 4);
    out_ready = 1'b1;
    drain(600);

    // Reset while in WAIT with two words queued
    push_word(16'hFFFF, 16);
    push_word(16'h00FF, 8);
    push_word(16'h000F, 4);
    repeat (3) tick();
    check("pre_rst_level", 32'(level), 2);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    exq.delete();
    check("mid_rst_level", 32'(level), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data", 32'(out_data), 0);
    check("mid_rst_core_go", 32'(core_go), 0);
    check("mid_rst_core_in", 32'(core_in), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    tick();
    rst = 1'b0;
    tick();
    push_word(16'h0007, 3);
    drain(100);
    repeat (20) tick();
    check("post_rst_no_extra", 32'(out_valid), 0);
    check("post_rst_level", 32'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
